ctrl_pipe: RTL

Consumer of the packed control bundle emitted by the decode-stage control generator. It registers the bundle through the ID/EX, EX/MEM and MEM/WB pipeline boundaries. At each boundary it retires the fields already consumed, so each stage sees only its own control signals. It also handles stall (bubble insertion), flush (branch-taken squash) and reserved-bit checking, and counts retired instructions.

---
 rtl/ctrl_pkg.sv | 50 +++++
 rtl/ctrl_stage_reg.sv | 29 ++
 rtl/ctrl_pipe.sv | 109 ++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Control-bundle layout shared by the decode-stage generator and ctrl_pipe.
// Bit positions, stage widths and per-stage control views.
package ctrl_pkg;

  localparam int CTRL_WIDTH      = 16;

  localparam int CTRL_ALUOP_HI   = 7;
  localparam int CTRL_ALUOP_LO   = 6;
  localparam int CTRL_ALUSRC     = 5;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_MEM_RE     = 3;
  localparam int CTRL_MEM_WE     = 2;
  localparam int CTRL_REG_WE     = 1;
  localparam int CTRL_MEM_TO_REG = 0;
  localparam int CTRL_RSVD_LO    = 8;

  localparam int EX_W  = 8;
  localparam int MEM_W = 5;
  localparam int WB_W  = 2;

  typedef logic [1:0] aluop_t;

  localparam aluop_t ALUOP_ADD    = 2'b00;
  localparam aluop_t ALUOP_BRANCH = 2'b01;
  localparam aluop_t ALUOP_FUNCT  = 2'b10;

  typedef struct packed {
    aluop_t aluop;
    logic   alusrc;
    logic   is_branch;
    logic   mem_re;
    logic   mem_we;
    logic   reg_we;
    logic   mem_to_reg;
  } ex_ctrl_t;

  typedef struct packed {
    logic is_branch;
    logic mem_re;
    logic mem_we;
    logic reg_we;
    logic mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_we;
    logic mem_to_reg;
  } wb_ctrl_t;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline boundary: control payload plus valid bit.
// A bubble load clears both payload and valid.
module ctrl_stage_reg
  import ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         vld_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_o   <= '0;
      vld_o <= 1'b0;
    end else if (bubble_i) begin
      q_o   <= '0;
      vld_o <= 1'b0;
    end else begin
      q_o   <= d_i;
      vld_o <= 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decode control through ID/EX, EX/MEM, MEM/WB with stall,
// flush, reserved-bit drop and a retired-instruction counter.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int CTRL_WIDTH = ctrl_pkg::CTRL_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_q2_i,
  input  logic                  id_vld_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [1:0]            ex_aluop_o,
  output logic                  ex_alusrc_o,
  output logic                  ex_mem_re_o,
  output logic                  ex_vld_o,
  output logic                  mem_is_branch_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic                  mem_vld_o,
  output logic                  wb_reg_we_o,
  output logic                  wb_is_mem_to_reg_o,
  output logic                  wb_vld_o,
  output logic [CNT_WIDTH-1:0]  retire_cnt_o,
  output logic                  rsvd_err_o
);

  ex_ctrl_t  ex_q;
  mem_ctrl_t mem_q;
  wb_ctrl_t  wb_q;

  logic ex_vld;
  logic mem_vld;
  logic wb_vld;

  logic rsvd_nz;
  logic rsvd_hit;
  logic ex_bubble;
  logic mem_bubble;
  logic wb_bubble;

  assign rsvd_nz  = |ctrl_q2_i[CTRL_WIDTH-1:CTRL_RSVD_LO];
  assign rsvd_hit = id_vld_i & ~stall_i & ~flush_i & rsvd_nz;

  // Flush outranks stall; both just turn EX into a bubble here.
  assign ex_bubble  = flush_i | stall_i | ~id_vld_i | rsvd_nz;
  assign mem_bubble = flush_i | ~ex_vld;
  assign wb_bubble  = ~mem_vld;

  ctrl_stage_reg #(.W(EX_W)) u_ex (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .bubble_i (ex_bubble),
    .d_i      (ctrl_q2_i[EX_W-1:0]),
    .q_o      (ex_q),
    .vld_o    (ex_vld)
  );

  ctrl_stage_reg #(.W(MEM_W)) u_mem (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .bubble_i (mem_bubble),
    .d_i      (ex_q[MEM_W-1:0]),
    .q_o      (mem_q),
    .vld_o    (mem_vld)
  );

  ctrl_stage_reg #(.W(WB_W)) u_wb (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .bubble_i (wb_bubble),
    .d_i      (mem_q[WB_W-1:0]),
    .q_o      (wb_q),
    .vld_o    (wb_vld)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsvd_err_o <= 1'b0;
    end else begin
      rsvd_err_o <= rsvd_hit;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      retire_cnt_o <= '0;
    end else if (wb_vld) begin
      retire_cnt_o <= retire_cnt_o + CNT_WIDTH'(1);
    end
  end

  assign ex_aluop_o  = ex_q.aluop;
  assign ex_alusrc_o = ex_q.alusrc;
  assign ex_mem_re_o = ex_q.mem_re & ex_vld;
  assign ex_vld_o    = ex_vld;

  assign mem_is_branch_o = mem_q.is_branch & mem_vld;
  assign mem_re_o        = mem_q.mem_re & mem_vld;
  assign mem_we_o        = mem_q.mem_we & mem_vld;
  assign mem_vld_o       = mem_vld;

  assign wb_reg_we_o        = wb_q.reg_we & wb_vld;
  assign wb_is_mem_to_reg_o = wb_q.mem_to_reg;
  assign wb_vld_o           = wb_vld;

endmodule
